voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
- Sits between song_reader and a bank of NUM_VOICES note_player instances, ahead of codec_conditioner.
- Allocates each new note from song_reader to a free voice, stealing the oldest voice when none is free.
- Tracks per-voice busy state from the done_with_note pulses.
- Collects one sample per voice for each codec request and emits one saturated mixed sample.

Parameters:
- NUM_VOICES, 4, number of note_player voices (power of two, 2..8)
- TIMEOUT, 255, max clk cycles to wait for all voice samples after generate_next_sample

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; top-level reset OR reset_player
- load_new_note  in  1  one-cycle pulse from song_reader
- note_to_load  in  6  note index; 0 = rest
- duration_to_load  in  6  duration in beats
- voice_done  in  NUM_VOICES  per-voice done_with_note pulses
- voice_load  out  NUM_VOICES  one-hot load_new_note to voices
- voice_note  out  6  registered note broadcast to all voices
- voice_duration  out  6  registered duration broadcast to all voices
- voice_busy  out  NUM_VOICES  busy mask
- generate_next_sample  in  1  one-cycle request from codec_conditioner
- voice_sample  in  16*NUM_VOICES  signed samples, voice i at bits [16i+15:16i]
- voice_sample_ready  in  NUM_VOICES  per-voice new_sample_ready pulses
- sample_out  out  16  signed mixed sample
- new_sample_ready  out  1  one-cycle pulse when sample_out updates
- timeout_flag  out  1  sticky; set when a mix completed by timeout

Behaviour:
Reset values:
- All outputs 0.
- Steal pointer 0, mixer state IDLE.

Allocation:
- Registered, 1-cycle latency.
- On load_new_note with note_to_load != 0:
  - Target = lowest-index voice with busy=0.
  - If all busy, target = steal pointer, which then increments mod NUM_VOICES.
  - Next cycle: voice_load[target]=1 for exactly one cycle; voice_note and voice_duration hold the loaded values; busy[target] set.
- note_to_load == 0 (rest): no voice_load, busy unchanged.
- busy[i] clears in the cycle after voice_done[i].
- Same-cycle voice_done[i] and allocation to i: busy[i] stays 1 (load wins). A voice freed by voice_done in the same cycle is not yet free for that allocation.
- voice_note and voice_duration hold their last values between loads.

Mixer FSM (IDLE, COLLECT, EMIT):
- IDLE: on generate_next_sample → COLLECT; clear got mask and accumulators; timer=0.
- COLLECT:
  - On voice_sample_ready[i] with got[i]=0, latch voice i sample and set got[i]. Repeat pulses are ignored.
  - A ready pulse coincident with the IDLE→COLLECT transition is captured.
  - All got bits set → EMIT.
  - Timer reaches TIMEOUT → EMIT; missing voices contribute 0; timeout_flag set.
- EMIT:
  - Sum latched samples sign-extended to 16+log2(NUM_VOICES) bits.
  - Saturate to [-32768, 32767] and register into sample_out.
  - new_sample_ready=1 this cycle only; → IDLE.
  - Latency: new_sample_ready asserts 2 cycles after the cycle in which the last ready pulse is sampled.
- generate_next_sample while in COLLECT or EMIT is ignored. It is not queued.
- sample_out holds between pulses.
- Allocation and mixer run concurrently and independently.
- Reset mid-operation returns both to their reset state immediately (asynchronous).

Decomposition:
- Package music_pkg:
  - NOTE_W=6, DUR_W=6, SAMPLE_W=16
  - REST_NOTE=0
  - mixer state enum
  - SAT_MAX/SAT_MIN constants
- One sub-module, sample_mixer: the COLLECT/EMIT FSM plus saturating adder. voice_scheduler keeps allocation and instantiates it.

Test Plan:
1. Four loads (notes 10, 11, 12, 13) with no voice_done → voice_load = 0001, 0010, 0100, 1000 on successive loads; voice_busy = 1111.
2. Fifth load (note 20) while all busy → voice 0 reloaded. Sixth load → voice 1. Steal pointer wraps after voice 3.
3. voice_done[2] pulse, then load note 30 → voice_load=0100, busy[2] remains 1. Same-cycle voice_done[1] with an allocation already targeting voice 1 → busy[1] stays 1.
4. load with note_to_load=0 → no voice_load, voice_busy unchanged.
5. generate_next_sample, then samples 1000, 2000, -500, 300 readied in scattered cycles → sample_out=2800; new_sample_ready pulses once, 2 cycles after the last ready. Samples 4×20000 → sample_out=32767. Samples 4×-20000 → sample_out=-32768.
6. generate_next_sample with voice 3 never ready → after 255 cycles, sum of voices 0–2 is emitted; timeout_flag=1 until reset. Reset asserted mid-COLLECT → outputs return to 0 and no pulse is emitted.

Source files
------------

// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared widths, saturation limits and mixer state for the voice scheduler
package music_pkg;
   localparam int NOTE_W   = 6;
   localparam int DUR_W    = 6;
   localparam int SAMPLE_W = 16;

   localparam logic [NOTE_W-1:0] REST_NOTE = '0;

   localparam int SAT_MAX = 32767;
   localparam int SAT_MIN = -32768;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      EMIT
   } mix_state_e;
endpackage

// File: rtl/sample_mixer.sv
// rtl/sample_mixer.sv - collects one sample per voice per request and emits a saturated sum
module sample_mixer
   import music_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           generate_next_sample,
   input  logic [SAMPLE_W*NUM_VOICES-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]          voice_sample_ready,
   output logic [SAMPLE_W-1:0]            sample_out,
   output logic                           new_sample_ready,
   output logic                           timeout_flag
);
   localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0]        TMR_LIMIT = TMR_W'(TIMEOUT);
   localparam logic signed [SUM_W-1:0] SUM_MAX   = SUM_W'(SAT_MAX);
   localparam logic signed [SUM_W-1:0] SUM_MIN   = SUM_W'(SAT_MIN);

   mix_state_e                 state_q, state_d;
   logic [NUM_VOICES-1:0]      got_q, got_d;
   logic signed [SAMPLE_W-1:0] samples_q [NUM_VOICES];
   logic signed [SAMPLE_W-1:0] samples_d [NUM_VOICES];
   logic [TMR_W-1:0]           timer_q, timer_d;
   logic [SAMPLE_W-1:0]        sample_out_q, sample_out_d;
   logic                       nsr_q, nsr_d;
   logic                       timeout_q, timeout_d;
   logic signed [SUM_W-1:0]    sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         got_q        <= '0;
         timer_q      <= '0;
         sample_out_q <= '0;
         nsr_q        <= 1'b0;
         timeout_q    <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) samples_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         got_q        <= got_d;
         timer_q      <= timer_d;
         sample_out_q <= sample_out_d;
         nsr_q        <= nsr_d;
         timeout_q    <= timeout_d;
         for (int i = 0; i < NUM_VOICES; i++) samples_q[i] <= samples_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (generate_next_sample) state_d = COLLECT;
         COLLECT: if ((&got_d) || (timer_q == TMR_LIMIT)) state_d = EMIT;
         EMIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         sum = sum + {{(SUM_W-SAMPLE_W){samples_q[i][SAMPLE_W-1]}}, samples_q[i]};
      end
   end

   always_comb begin
      got_d        = got_q;
      timer_d      = timer_q;
      sample_out_d = sample_out_q;
      nsr_d        = 1'b0;
      timeout_d    = timeout_q;
      for (int i = 0; i < NUM_VOICES; i++) samples_d[i] = samples_q[i];
      case (state_q)
         IDLE: begin
            // Ready pulses arriving with the request are captured so no voice is lost.
            if (generate_next_sample) begin
               got_d   = voice_sample_ready;
               timer_d = '0;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  samples_d[i] = voice_sample_ready[i] ? voice_sample[SAMPLE_W*i +: SAMPLE_W] : '0;
               end
            end
         end
         COLLECT: begin
            timer_d = timer_q + TMR_W'(1);
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (voice_sample_ready[i] && !got_q[i]) begin
                  samples_d[i] = voice_sample[SAMPLE_W*i +: SAMPLE_W];
                  got_d[i]     = 1'b1;
               end
            end
            if (!(&got_d) && (timer_q == TMR_LIMIT)) timeout_d = 1'b1;
         end
         EMIT: begin
            nsr_d = 1'b1;
            if (sum > SUM_MAX)      sample_out_d = SUM_MAX[SAMPLE_W-1:0];
            else if (sum < SUM_MIN) sample_out_d = SUM_MIN[SAMPLE_W-1:0];
            else                    sample_out_d = sum[SAMPLE_W-1:0];
         end
         default: ;
      endcase
   end

   assign sample_out       = sample_out_q;
   assign new_sample_ready = nsr_q;
   assign timeout_flag     = timeout_q;
endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - allocates notes to free or oldest voices and mixes their samples
module voice_scheduler
   import music_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           load_new_note,
   input  logic [NOTE_W-1:0]              note_to_load,
   input  logic [DUR_W-1:0]               duration_to_load,
   input  logic [NUM_VOICES-1:0]          voice_done,
   output logic [NUM_VOICES-1:0]          voice_load,
   output logic [NOTE_W-1:0]              voice_note,
   output logic [DUR_W-1:0]               voice_duration,
   output logic [NUM_VOICES-1:0]          voice_busy,
   input  logic                           generate_next_sample,
   input  logic [SAMPLE_W*NUM_VOICES-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]          voice_sample_ready,
   output logic [SAMPLE_W-1:0]            sample_out,
   output logic                           new_sample_ready,
   output logic                           timeout_flag
);
   localparam int VIDX_W = $clog2(NUM_VOICES);

   logic [NUM_VOICES-1:0] load_q, load_d;
   logic [NUM_VOICES-1:0] busy_q, busy_d;
   logic [NOTE_W-1:0]     note_q, note_d;
   logic [DUR_W-1:0]      dur_q, dur_d;
   logic [VIDX_W-1:0]     steal_q, steal_d;
   logic [VIDX_W-1:0]     target;
   logic                  found_free;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_q  <= '0;
         busy_q  <= '0;
         note_q  <= '0;
         dur_q   <= '0;
         steal_q <= '0;
      end else begin
         load_q  <= load_d;
         busy_q  <= busy_d;
         note_q  <= note_d;
         dur_q   <= dur_d;
         steal_q <= steal_d;
      end
   end

   // Free-voice search uses the registered busy mask, so a same-cycle done does not free a voice.
   always_comb begin
      found_free = 1'b0;
      target     = steal_q;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            found_free = 1'b1;
            target     = VIDX_W'(i);
         end
      end
   end

   always_comb begin
      load_d  = '0;
      busy_d  = busy_q & ~voice_done;
      note_d  = note_q;
      dur_d   = dur_q;
      steal_d = steal_q;
      if (load_new_note && (note_to_load != REST_NOTE)) begin
         load_d[target] = 1'b1;
         busy_d         = busy_d | load_d;
         note_d         = note_to_load;
         dur_d          = duration_to_load;
         if (!found_free) steal_d = steal_q + VIDX_W'(1);
      end
   end

   assign voice_load     = load_q;
   assign voice_busy     = busy_q;
   assign voice_note     = note_q;
   assign voice_duration = dur_q;

   sample_mixer #(
      .NUM_VOICES (NUM_VOICES),
      .TIMEOUT    (TIMEOUT)
   ) u_mixer (
      .clk                  (clk),
      .reset                (reset),
      .generate_next_sample (generate_next_sample),
      .voice_sample         (voice_sample),
      .voice_sample_ready   (voice_sample_ready),
      .sample_out           (sample_out),
      .new_sample_ready     (new_sample_ready),
      .timeout_flag         (timeout_flag)
   );
endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - scoreboard bench for voice allocation and sample mixing
module tb_voice_scheduler;
   localparam int NV  = 4;
   localparam int TMO = 255;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           load_new_note = 1'b0;
   logic [5:0]     note_to_load = '0;
   logic [5:0]     duration_to_load = '0;
   logic [NV-1:0]  voice_done = '0;
   logic [NV-1:0]  voice_load;
   logic [5:0]     voice_note;
   logic [5:0]     voice_duration;
   logic [NV-1:0]  voice_busy;
   logic           generate_next_sample = 1'b0;
   logic [16*NV-1:0] voice_sample = '0;
   logic [NV-1:0]  voice_sample_ready = '0;
   logic [15:0]    sample_out;
   logic           new_sample_ready;
   logic           timeout_flag;

   typedef struct { int mask; int note; int dur; } load_t;
   typedef struct { int val; int cyc; } mix_t;

   load_t load_exp[$];
   mix_t  mix_exp[$];
   load_t le;
   mix_t  me;
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;

   voice_scheduler #(.NUM_VOICES(NV), .TIMEOUT(TMO)) dut (
      .clk                  (clk),
      .reset                (rst),
      .load_new_note        (load_new_note),
      .note_to_load         (note_to_load),
      .duration_to_load     (duration_to_load),
      .voice_done           (voice_done),
      .voice_load           (voice_load),
      .voice_note           (voice_note),
      .voice_duration       (voice_duration),
      .voice_busy           (voice_busy),
      .generate_next_sample (generate_next_sample),
      .voice_sample         (voice_sample),
      .voice_sample_ready   (voice_sample_ready),
      .sample_out           (sample_out),
      .new_sample_ready     (new_sample_ready),
      .timeout_flag         (timeout_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (voice_load != '0) begin
            if (load_exp.size() == 0) begin
               check("unexpected_voice_load", int'(voice_load), 0);
            end else begin
               le = load_exp.pop_front();
               check("voice_load", int'(voice_load), le.mask);
               check("voice_note", int'(voice_note), le.note);
               check("voice_duration", int'(voice_duration), le.dur);
            end
         end
         if (new_sample_ready) begin
            if (mix_exp.size() == 0) begin
               check("unexpected_sample_pulse", int'($signed(sample_out)), 0);
            end else begin
               me = mix_exp.pop_front();
               check("sample_out", int'($signed(sample_out)), me.val);
               check("mix_latency", cyc, me.cyc);
            end
         end
      end
   end

   task automatic do_load(input int note, input int done, input int exp_mask);
      load_t t;
      @(posedge clk); #1;
      load_new_note    = 1'b1;
      note_to_load     = 6'(note);
      duration_to_load = 6'(note + 1);
      voice_done       = NV'(done);
      if (exp_mask != 0) begin
         t.mask = exp_mask;
         t.note = note;
         t.dur  = (note + 1) & 63;
         load_exp.push_back(t);
      end
      @(posedge clk); #1;
      load_new_note = 1'b0;
      voice_done    = '0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_done(input int mask);
      @(posedge clk); #1;
      voice_done = NV'(mask);
      @(posedge clk); #1;
      voice_done = '0;
   endtask

   // Offset -1 means the voice never becomes ready; voice 0 repeats its pulse with junk data.
   task automatic run_mix(input int s0, input int s1, input int s2, input int s3,
                          input int o0, input int o1, input int o2, input int o3);
      int s[NV];
      int o[NV];
      int maxo, sum, last, g;
      bit to;
      mix_t t;
      s = '{s0, s1, s2, s3};
      o = '{o0, o1, o2, o3};
      maxo = 0; sum = 0; last = 0; to = 1'b0;
      for (int i = 0; i < NV; i++) begin
         if (o[i] >= 0) begin
            sum += s[i];
            if (o[i] > maxo) maxo = o[i];
         end else begin
            to = 1'b1;
         end
      end
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      @(posedge clk); #1;
      g = cyc;
      for (int c = 0; c <= maxo; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         generate_next_sample = (c == 0) || (c == 2);
         for (int i = 0; i < NV; i++) begin
            voice_sample_ready[i] = (o[i] == c) || (i == 0 && o[0] >= 0 && c > o[0]);
            voice_sample[16*i +: 16] = (o[i] == c) ? 16'(s[i]) : 16'h5a5a;
            if (o[i] == c) last = cyc;
         end
      end
      @(posedge clk); #1;
      generate_next_sample = 1'b0;
      voice_sample_ready   = '0;
      t.val = sum;
      t.cyc = to ? g + TMO + 3 : last + 2;
      mix_exp.push_back(t);
      for (int k = 0; k < 400 && mix_exp.size() != 0; k++) @(posedge clk);
      if (mix_exp.size() != 0) begin
         check("mix_wait_expired", mix_exp.size(), 0);
         mix_exp.delete();
      end
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_voice_load", int'(voice_load), 0);
      check("reset_voice_busy", int'(voice_busy), 0);
      check("reset_voice_note", int'(voice_note), 0);
      check("reset_sample_out", int'(sample_out), 0);
      check("reset_new_sample_ready", int'(new_sample_ready), 0);
      check("reset_timeout_flag", int'(timeout_flag), 0);
      rst = 1'b0;

      do_load(10, 0, 4'b0001);
      do_load(11, 0, 4'b0010);
      do_load(12, 0, 4'b0100);
      do_load(13, 0, 4'b1000);
      check("busy_all", int'(voice_busy), 4'b1111);

      do_load(20, 0, 4'b0001);
      do_load(21, 0, 4'b0010);
      do_load(22, 0, 4'b0100);
      do_load(23, 0, 4'b1000);
      do_load(24, 0, 4'b0001);
      check("busy_after_steals", int'(voice_busy), 4'b1111);

      pulse_done(4'b0100);
      check("busy_after_done2", int'(voice_busy), 4'b1011);
      do_load(30, 0, 4'b0100);
      check("busy_reload2", int'(voice_busy), 4'b1111);

      pulse_done(4'b0010);
      check("busy_after_done1", int'(voice_busy), 4'b1101);
      do_load(31, 4'b0010, 4'b0010);
      check("busy_load_wins", int'(voice_busy), 4'b1111);

      do_load(32, 4'b1000, 4'b0010);
      check("busy_same_cycle_done", int'(voice_busy), 4'b0111);

      do_load(0, 0, 0);
      check("busy_after_rest", int'(voice_busy), 4'b0111);
      check("note_holds_after_rest", int'(voice_note), 32);
      check("load_queue_drained", load_exp.size(), 0);

      run_mix(1000, 2000, -500, 300, 3, 1, 6, 4);
      run_mix(20000, 20000, 20000, 20000, 0, 2, 0, 1);
      run_mix(-20000, -20000, -20000, -20000, 2, 2, 2, 2);
      check("timeout_flag_clear", int'(timeout_flag), 0);

      run_mix(1000, 2000, 3000, 5000, 1, 2, 3, -1);
      check("timeout_flag_set", int'(timeout_flag), 1);
      repeat (5) @(posedge clk);
      #1;
      check("timeout_flag_sticky", int'(timeout_flag), 1);
      check("sample_out_holds", int'($signed(sample_out)), 6000);

      @(posedge clk); #1;
      generate_next_sample  = 1'b1;
      voice_sample_ready    = 4'b0001;
      voice_sample[15:0]    = 16'd777;
      @(posedge clk); #1;
      generate_next_sample  = 1'b0;
      voice_sample_ready    = '0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midreset_sample_out", int'(sample_out), 0);
      check("midreset_timeout_flag", int'(timeout_flag), 0);
      check("midreset_busy", int'(voice_busy), 0);
      check("midreset_voice_note", int'(voice_note), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      check("no_pulse_after_reset", int'(new_sample_ready), 0);

      run_mix(100, 200, 300, 400, 0, 1, 2, 3);
      check("timeout_flag_after_reset_mix", int'(timeout_flag), 0);
      check("mix_queue_drained", mix_exp.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
